rename_regfile: RTL and testbench
=================================

// Module: rename_regfile
// PURPOSE
// Architectural register file plus rename-tag table. It is the commit-side consumer of the
// reorder buffer's retire interface (rd / value / rob id / clear) and the issue-side producer of
// operand values or ROB dependency tags for the instruction unit.
// Issue renames a destination to its ROB slot; commit writes the value and releases the tag if
// it still matches; a misprediction clear drops every pending tag.
// PARAMETERS
// ROB_IDX_W   4    width of a ROB index / rename tag (ROB capacity = 2**ROB_IDX_W)
// XLEN        32   register data width
// PORTS
// clk_in           in   1          clock, all state updates on rising edge
// rst_n_in         in   1          asynchronous reset, active low
// rdy_in           in   1          global ready; low = hold all state
// issue_req_in     in   1          instruction issued this cycle (same strobe the ROB allocates on)
// issue_rd_in      in   5          destination register of issued instruction
// issue_rob_id_in  in   ROB_IDX_W  ROB slot allocated to it (ROB tail)
// rs1_in / rs2_in  in   5          source register addresses of the instruction being issued
// rs1_val_out      out  XLEN       rs1 value (valid when rs1_busy_out=0)
// rs1_busy_out     out  1          rs1 pending on an uncommitted producer
// rs1_tag_out      out  ROB_IDX_W  ROB id of that producer (valid when busy)
// rs2_val_out / rs2_busy_out / rs2_tag_out   out   same as rs1
// commit_rd_in     out-of-ROB in 5 committed destination; 0 = no write
// commit_val_in    in   XLEN       committed value
// commit_rob_id_in in   ROB_IDX_W  ROB id of committing entry
// clear_in         in   1          misprediction flush from ROB
// BEHAVIOUR
// - State: val[32] XLEN, busy[32], tag[32]. x0: val=0, busy=0 always; writes/renames to x0 ignored.
// - Reset (rst_n_in low, async): all val=0, busy=0, tag=0; outputs therefore 0 (combinational).
// - Reads combinational, zero latency, from pre-edge state (an instruction's own rename never
//   affects its own source reads, including rd==rs1).
// - Clock edge, rdy_in high, priority in order:
//   1. commit: commit_rd_in!=0 -> val[rd]<=commit_val_in; if busy[rd] && tag[rd]==commit_rob_id_in
//      -> busy[rd]<=0 (stale tag mismatch keeps busy; a repeated identical commit is idempotent).
//   2. clear_in=1 -> busy[all]<=0; issue this cycle ignored; commit write of step 1 still applied.
//   3. issue (clear_in=0): issue_req_in && issue_rd_in!=0 -> busy<=1, tag<=issue_rob_id_in;
//      overrides step-1 release of the same register in the same cycle.
// - rdy_in low: no state change, reads still driven; reset still acts.
// - Tag width arithmetic: exact equality on ROB_IDX_W bits; wrap of ROB ids needs no special case
//   because a reg's tag is always the newest in-flight producer.
// CONFIGURATION
// RF_BYPASS_EN defined: read port whose register is busy with tag==commit_rob_id_in and
//   commit_rd_in==rsX!=0 returns busy=0, val=commit_val_in in the same cycle.
// RF_BYPASS_EN undefined: reads return stored state only; consumer must snoop the CDB broadcast
//   of the same cycle to capture the value (one extra cycle of tag-wait worst case).
// TESTING
// reset: rst_n_in low mid-run -> all busy_out=0, val_out=0 immediately, no clock needed.
// issue rd=5 tag=3, next cycle read rs1=5 -> busy=1 tag=3; commit rd=5 id=3 val=0xDEAD -> next read
//   busy=0 val=0xDEAD.
// WAW: issue rd=7 tag=2 then rd=7 tag=4; commit rd=7 id=2 val=1 -> busy stays 1 tag=4, val=1.
// same cycle commit rd=9 id=1 (tag 1) + issue rd=9 tag=6 -> busy=1 tag=6, val=commit value.
// clear_in with issue rd=4 tag=5 -> all busy=0 next cycle, reg 4 not renamed.
// RF_BYPASS_EN: busy x3 tag=8, commit rd=3 id=8 val=0x55 with rs2_in=3 -> same cycle busy=0 val=0x55;
//   without macro -> busy=1 tag=8; x0: issue/commit rd=0 -> read x0 val=0 busy=0.

Source files
------------

// File: rtl/rename_regfile.sv
// Architectural register file with per-register rename tags (ROB id of newest producer).
// Optional same-cycle commit forwarding on the read ports is enabled by defining RF_BYPASS_EN.
module rename_regfile #(
  parameter int ROB_IDX_W = 4,
  parameter int XLEN      = 32
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 rdy_in,
  input  logic                 issue_req_in,
  input  logic [4:0]           issue_rd_in,
  input  logic [ROB_IDX_W-1:0] issue_rob_id_in,
  input  logic [4:0]           rs1_in,
  input  logic [4:0]           rs2_in,
  output logic [XLEN-1:0]      rs1_val_out,
  output logic                 rs1_busy_out,
  output logic [ROB_IDX_W-1:0] rs1_tag_out,
  output logic [XLEN-1:0]      rs2_val_out,
  output logic                 rs2_busy_out,
  output logic [ROB_IDX_W-1:0] rs2_tag_out,
  input  logic [4:0]           commit_rd_in,
  input  logic [XLEN-1:0]      commit_val_in,
  input  logic [ROB_IDX_W-1:0] commit_rob_id_in,
  input  logic                 clear_in
);

  logic [XLEN-1:0]      val_q  [32];
  logic                 busy_q [32];
  logic [ROB_IDX_W-1:0] tag_q  [32];

  logic commit_en;
  logic commit_release;
  logic issue_en;

  assign commit_en      = (commit_rd_in != 5'd0);
  assign commit_release = commit_en && busy_q[commit_rd_in] &&
                          (tag_q[commit_rd_in] == commit_rob_id_in);
  assign issue_en       = issue_req_in && (issue_rd_in != 5'd0) && !clear_in;

  // Later non-blocking writes win, so a same-cycle rename overrides the commit release.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < 32; i++) begin
        val_q[i]  <= '0;
        busy_q[i] <= 1'b0;
        tag_q[i]  <= '0;
      end
    end else if (rdy_in) begin
      if (commit_en) begin
        val_q[commit_rd_in] <= commit_val_in;
        if (commit_release) busy_q[commit_rd_in] <= 1'b0;
      end
      if (clear_in) begin
        for (int i = 0; i < 32; i++) busy_q[i] <= 1'b0;
      end else if (issue_en) begin
        busy_q[issue_rd_in] <= 1'b1;
        tag_q[issue_rd_in]  <= issue_rob_id_in;
      end
    end
  end

`ifdef RF_BYPASS_EN
  function automatic logic fwd_hit(input logic [4:0] rs);
    return (rs != 5'd0) && (commit_rd_in == rs) && busy_q[rs] &&
           (tag_q[rs] == commit_rob_id_in);
  endfunction
`endif

  always_comb begin
    rs1_val_out  = val_q[rs1_in];
    rs1_busy_out = busy_q[rs1_in];
    rs1_tag_out  = tag_q[rs1_in];
    rs2_val_out  = val_q[rs2_in];
    rs2_busy_out = busy_q[rs2_in];
    rs2_tag_out  = tag_q[rs2_in];
`ifdef RF_BYPASS_EN
    if (fwd_hit(rs1_in)) begin
      rs1_busy_out = 1'b0;
      rs1_val_out  = commit_val_in;
    end
    if (fwd_hit(rs2_in)) begin
      rs2_busy_out = 1'b0;
      rs2_val_out  = commit_val_in;
    end
`endif
  end

endmodule

// File: tb/tb_rename_regfile.sv
// Directed bench for rename_regfile; expected reads are queued with stimulus and checked on output.
module tb_rename_regfile;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        rdy_in;
  logic        issue_req_in;
  logic [4:0]  issue_rd_in;
  logic [3:0]  issue_rob_id_in;
  logic [4:0]  rs1_in, rs2_in;
  logic [31:0] rs1_val_out, rs2_val_out;
  logic        rs1_busy_out, rs2_busy_out;
  logic [3:0]  rs1_tag_out, rs2_tag_out;
  logic [4:0]  commit_rd_in;
  logic [31:0] commit_val_in;
  logic [3:0]  commit_rob_id_in;
  logic        clear_in;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    int          port;
    logic        busy;
    logic [3:0]  tag;
    logic [31:0] val;
    bit          chk_tag;
  } exp_t;

  exp_t sb[$];

  rename_regfile #(.ROB_IDX_W(4), .XLEN(32)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .issue_req_in(issue_req_in), .issue_rd_in(issue_rd_in), .issue_rob_id_in(issue_rob_id_in),
    .rs1_in(rs1_in), .rs2_in(rs2_in),
    .rs1_val_out(rs1_val_out), .rs1_busy_out(rs1_busy_out), .rs1_tag_out(rs1_tag_out),
    .rs2_val_out(rs2_val_out), .rs2_busy_out(rs2_busy_out), .rs2_tag_out(rs2_tag_out),
    .commit_rd_in(commit_rd_in), .commit_val_in(commit_val_in),
    .commit_rob_id_in(commit_rob_id_in), .clear_in(clear_in)
  );

  always #5 clk_in = ~clk_in;

  task automatic expect_rd(input string n, input int p, input logic b, input logic [3:0] t,
                           input logic [31:0] v, input bit ct);
    exp_t e;
    e.name = n; e.port = p; e.busy = b; e.tag = t; e.val = v; e.chk_tag = ct;
    sb.push_back(e);
  endtask

  task automatic check_all();
    exp_t        e;
    logic        ob;
    logic [3:0]  ot;
    logic [31:0] ov;
    #1;
    while (sb.size() > 0) begin
      e  = sb.pop_front();
      ob = (e.port == 1) ? rs1_busy_out : rs2_busy_out;
      ot = (e.port == 1) ? rs1_tag_out  : rs2_tag_out;
      ov = (e.port == 1) ? rs1_val_out  : rs2_val_out;
      checks++;
      assert (ob === e.busy) else begin
        errors++;
        $error("FAIL %s busy observed %0b expected %0b", e.name, ob, e.busy);
      end
      checks++;
      assert (ov === e.val) else begin
        errors++;
        $error("FAIL %s val observed %h expected %h", e.name, ov, e.val);
      end
      if (e.chk_tag) begin
        checks++;
        assert (ot === e.tag) else begin
          errors++;
          $error("FAIL %s tag observed %0d expected %0d", e.name, ot, e.tag);
        end
      end
    end
  endtask

  task automatic idle();
    issue_req_in = 1'b0; issue_rd_in = 5'd0; issue_rob_id_in = 4'd0;
    commit_rd_in = 5'd0; commit_val_in = 32'd0; commit_rob_id_in = 4'd0;
    clear_in = 1'b0; rs1_in = 5'd0; rs2_in = 5'd0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [3:0] id);
    issue_req_in = 1'b1; issue_rd_in = rd; issue_rob_id_in = id;
  endtask

  task automatic commit(input logic [4:0] rd, input logic [3:0] id, input logic [31:0] v);
    commit_rd_in = rd; commit_rob_id_in = id; commit_val_in = v;
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    rst_n_in = 1'b0;
    rdy_in   = 1'b1;
    idle();
    rs1_in = 5'd5; rs2_in = 5'd31;
    expect_rd("reset_rs1", 1, 1'b0, 4'd0, 32'd0, 1'b1);
    expect_rd("reset_rs2", 2, 1'b0, 4'd0, 32'd0, 1'b1);
    check_all();
    tick(); tick();
    @(negedge clk_in);
    rst_n_in = 1'b1;
    tick();

    // Own rename does not affect own source read.
    issue(5'd5, 4'd3); rs1_in = 5'd5;
    expect_rd("own_rename", 1, 1'b0, 4'd0, 32'd0, 1'b0);
    check_all();
    tick(); idle(); rs1_in = 5'd5;
    expect_rd("rename_r5", 1, 1'b1, 4'd3, 32'd0, 1'b1);
    check_all();

    commit(5'd5, 4'd3, 32'hDEAD);
    tick(); idle(); rs1_in = 5'd5;
    expect_rd("commit_r5", 1, 1'b0, 4'd0, 32'hDEAD, 1'b0);
    check_all();
    commit(5'd5, 4'd3, 32'hDEAD);
    tick(); idle(); rs1_in = 5'd5;
    expect_rd("recommit_r5", 1, 1'b0, 4'd0, 32'hDEAD, 1'b0);
    check_all();

    // WAW: stale commit writes value but keeps newest tag busy.
    issue(5'd7, 4'd2); tick();
    issue(5'd7, 4'd4); tick(); idle();
    commit(5'd7, 4'd2, 32'd1); tick(); idle(); rs2_in = 5'd7;
    expect_rd("waw_r7", 2, 1'b1, 4'd4, 32'd1, 1'b1);
    check_all();

    // Same-cycle commit release and rename of one register.
    issue(5'd9, 4'd1); tick(); idle();
    commit(5'd9, 4'd1, 32'h99); issue(5'd9, 4'd6);
    tick(); idle(); rs1_in = 5'd9;
    expect_rd("commit_issue_r9", 1, 1'b1, 4'd6, 32'h99, 1'b1);
    check_all();

    // Clear drops all tags, ignores issue, keeps commit write.
    clear_in = 1'b1; issue(5'd4, 4'd5); commit(5'd11, 4'd0, 32'h11);
    tick(); idle(); rs1_in = 5'd4; rs2_in = 5'd7;
    expect_rd("clear_r4", 1, 1'b0, 4'd0, 32'd0, 1'b0);
    expect_rd("clear_r7", 2, 1'b0, 4'd0, 32'd1, 1'b0);
    check_all();
    rs1_in = 5'd9; rs2_in = 5'd11;
    expect_rd("clear_r9", 1, 1'b0, 4'd0, 32'h99, 1'b0);
    expect_rd("clear_r11", 2, 1'b0, 4'd0, 32'h11, 1'b0);
    check_all();

    // Commit forwarding on the read port, or stored state without it.
    issue(5'd3, 4'd8); tick(); idle();
    commit(5'd3, 4'd8, 32'h55); rs2_in = 5'd3;
`ifdef RF_BYPASS_EN
    expect_rd("bypass_r3", 2, 1'b0, 4'd0, 32'h55, 1'b0);
`else
    expect_rd("nobypass_r3", 2, 1'b1, 4'd8, 32'd0, 1'b1);
`endif
    check_all();
    tick(); idle(); rs2_in = 5'd3;
    expect_rd("after_commit_r3", 2, 1'b0, 4'd0, 32'h55, 1'b0);
    check_all();

    // x0 ignores rename and commit.
    issue(5'd0, 4'd7); commit(5'd0, 4'd7, 32'hFFFF);
    tick(); idle(); rs1_in = 5'd0;
    expect_rd("x0", 1, 1'b0, 4'd0, 32'd0, 1'b1);
    check_all();

    // rdy_in low holds state; reads still driven.
    rdy_in = 1'b0; issue(5'd12, 4'd2); commit(5'd11, 4'd0, 32'hBAD); rs1_in = 5'd9;
    expect_rd("rdy_low_read", 1, 1'b0, 4'd0, 32'h99, 1'b0);
    check_all();
    tick(); idle(); rdy_in = 1'b1; rs1_in = 5'd12; rs2_in = 5'd11;
    expect_rd("rdy_low_r12", 1, 1'b0, 4'd0, 32'd0, 1'b0);
    expect_rd("rdy_low_r11", 2, 1'b0, 4'd0, 32'h11, 1'b0);
    check_all();

    // Asynchronous reset mid-run.
    issue(5'd13, 4'd9); tick(); idle(); rs1_in = 5'd13; rs2_in = 5'd9;
    expect_rd("pre_rst_r13", 1, 1'b1, 4'd9, 32'd0, 1'b1);
    check_all();
    rst_n_in = 1'b0;
    expect_rd("async_rst_r13", 1, 1'b0, 4'd0, 32'd0, 1'b1);
    expect_rd("async_rst_r9", 2, 1'b0, 4'd0, 32'd0, 1'b1);
    check_all();
    @(negedge clk_in);
    rst_n_in = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
